uart_mem_master: RTL and testbench

- Host-side controller that shares one UART link to the remote UART memory between two local requesters.
- Arbitrates round-robin between the requesters and serializes each granted access into the memory command protocol:
  - Write: opcode frame, address frame, data frame.
  - Read: opcode frame, address frame, then one response frame.
- Drives a local UART_tx/UART_rx pair through their trmt/tx_done/clr_tx_done and rx_done/clr_rx_done handshakes.
- Returns completion, read data and timeout status to the requester.

---
 rtl/uart_mem_pkg.sv | 15 +
 rtl/rr_arb2.sv | 30 +++
 rtl/uart_mem_master.sv | 143 ++++++++++++++
 tb/tb_uart_mem_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_pkg.sv
// Shared opcode encodings and FSM state type for the UART memory host master.
package uart_mem_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_ADDR,
    SEND_DATA,
    WAIT_RSP
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer holds the index of the last requester served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt_onehot
);

  logic last;

  // On contention the requester that was not served last wins.
  always_comb begin
    gnt_onehot = '0;
    case (req)
      2'b01:   gnt_onehot = 2'b01;
      2'b10:   gnt_onehot = 2'b10;
      2'b11:   gnt_onehot = last ? 2'b01 : 2'b10;
      default: gnt_onehot = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      last <= 1'b1;
    else if (advance && (gnt_onehot != '0))
      last <= gnt_onehot[1];
  end

endmodule

// File: rtl/uart_mem_master.sv
// Shares one UART link to the remote memory between two requesters, serialising
// each granted access into opcode/address/data frames and collecting read responses.
module uart_mem_master
  import uart_mem_pkg::*;
#(
  parameter int FRAME_WIDTH    = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              gnt,
  output logic [1:0]              done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic                    busy,
  output logic                    trmt,
  output logic [FRAME_WIDTH-1:0]  tx_data,
  input  logic                    tx_done,
  output logic                    clr_tx_done,
  input  logic [FRAME_WIDTH-1:0]  rx_data,
  input  logic                    rx_done,
  output logic                    clr_rx_done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  state_t                  state, next;
  logic [1:0]              arb_gnt;
  logic                    grant;
  logic                    sel;
  logic                    owner;
  logic                    op_we;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [DATA_WIDTH-1:0]   op_wdata;
  logic [CW-1:0]           cnt;
  logic                    timeout;
  logic                    unused_rx;

  assign grant     = (state == IDLE) && (req != '0);
  assign sel       = arb_gnt[1];
  assign timeout   = (cnt == TMO);
  assign busy      = (state != IDLE);
  assign unused_rx = ^rx_data;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_l      (rst_l),
    .req        (req),
    .advance    (grant),
    .gnt_onehot (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:      if (req != '0) next = SEND_OP;
      SEND_OP:   if (tx_done) next = SEND_ADDR;
      SEND_ADDR: if (tx_done) next = (op_we == OP_WRITE) ? SEND_DATA : WAIT_RSP;
      SEND_DATA: if (tx_done) next = IDLE;
      WAIT_RSP:  if (rx_done || timeout) next = IDLE;
      default:   next = IDLE;
    endcase
  end

  // rx_done outside WAIT_RSP is a stray frame: acknowledge it and drop it.
  always_comb begin
    gnt         = '0;
    done        = '0;
    err         = 1'b0;
    trmt        = 1'b0;
    clr_tx_done = 1'b0;
    clr_rx_done = 1'b0;
    tx_data     = '0;
    case (state)
      IDLE: begin
        gnt         = arb_gnt;
        clr_rx_done = rx_done;
      end
      SEND_OP, SEND_ADDR, SEND_DATA: begin
        trmt        = ~tx_done;
        clr_tx_done = tx_done;
        clr_rx_done = rx_done;
        case (state)
          SEND_OP:   tx_data = FRAME_WIDTH'(op_we);
          SEND_ADDR: tx_data = FRAME_WIDTH'(op_addr);
          default:   tx_data = FRAME_WIDTH'(op_wdata);
        endcase
        if ((state == SEND_DATA) && tx_done)
          done[owner] = 1'b1;
      end
      WAIT_RSP: begin
        if (rx_done) begin
          clr_rx_done = 1'b1;
          done[owner] = 1'b1;
        end else if (timeout) begin
          done[owner] = 1'b1;
          err         = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counter is held clear outside WAIT_RSP, so it starts from zero on entry.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      owner    <= 1'b0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      if (grant) begin
        owner    <= sel;
        op_we    <= sel ? we[1] : we[0];
        op_addr  <= sel ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
        op_wdata <= sel ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
      end
      if (state != WAIT_RSP)
        cnt <= '0;
      else if (!timeout)
        cnt <= cnt + CW'(1);
      if ((state == WAIT_RSP) && rx_done)
        rdata <= rx_data[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_uart_mem_master.sv
// Randomised scoreboard bench: a remote UART/memory model answers the link while a
// monitor compares frames, grants and completions against a reference model.
module tb_uart_mem_master;

  localparam int FW  = 8;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0]      we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]      gnt, done;
  logic [DW-1:0]   rdata;
  logic            err, busy, trmt, clr_tx_done, clr_rx_done;
  logic [FW-1:0]   tx_data;
  logic            tx_done = 1'b0;
  logic            rx_done = 1'b0;
  logic [FW-1:0]   rx_data = '0;

  always #5 clk = ~clk;

  uart_mem_master #(
    .FRAME_WIDTH    (FW),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .busy        (busy),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .clr_tx_done (clr_tx_done),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .clr_rx_done (clr_rx_done)
  );

  typedef struct packed {
    logic [1:0]    d;
    logic          e;
    logic [DW-1:0] r;
    logic          tmo;
  } done_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [FW-1:0] exp_frames[$];
  done_t         exp_done[$];
  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] ref_last = '0;
  int  ref_ptr = 1;
  bit  mute = 0;
  int  stray_cnt = 0;
  bit  stray_cleared = 0;
  int  frames_seen = 0;
  int  last_clr_tx_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Remote side: UART_tx/UART_rx plus the memory at the far end of the link.
  initial begin : remote
    logic [7:0] rmem[16];
    bit         tbusy, rsp, op;
    int         tdly, rdly, nfr, stray_ack;
    logic [7:0] cur;
    logic [3:0] ra;
    logic       n_txd, n_rxd;
    logic [7:0] n_rxdat;
    foreach (rmem[k]) rmem[k] = '0;
    tbusy = 0; rsp = 0; op = 0; tdly = 0; rdly = 0; nfr = 0; stray_ack = 0;
    cur = '0; ra = '0;
    forever begin
      @(negedge clk);
      n_txd = tx_done; n_rxd = rx_done; n_rxdat = rx_data;
      if (!rst_l) begin
        tbusy = 0; rsp = 0; nfr = 0; n_txd = 0; n_rxd = 0;
      end else begin
        if (clr_tx_done) begin
          n_txd = 0;
          nfr++;
          if (nfr == 1) op = cur[0];
          else if (nfr == 2) begin
            ra = cur[3:0];
            if (!op) begin
              nfr = 0;
              if (!mute) begin rsp = 1; rdly = $urandom_range(0, 6); end
            end
          end else begin
            rmem[ra] = cur;
            nfr = 0;
          end
        end else if (tbusy) begin
          if (tdly == 0) begin n_txd = 1; tbusy = 0; end
          else tdly--;
        end else if (trmt && !tx_done) begin
          cur = tx_data; tbusy = 1; tdly = $urandom_range(0, 4);
        end
        if (clr_rx_done) begin
          n_rxd = 0;
          if (!busy) stray_cleared = 1;
        end
        if (rsp) begin
          if (rdly == 0) begin n_rxdat = rmem[ra]; n_rxd = 1; rsp = 0; end
          else rdly--;
        end
        if (stray_cnt != stray_ack) begin
          n_rxdat = 8'h55; n_rxd = 1; stray_ack++;
        end
      end
      @(posedge clk); #1;
      tx_done = n_txd; rx_done = n_rxd; rx_data = n_rxdat;
    end
  end

  // Monitor: grants vs. round-robin reference, frames and completions vs. scoreboard.
  initial begin : monitor
    bit         tprev, rdchk;
    logic [7:0] dprev, rdexp;
    logic [1:0] eg;
    done_t      it;
    tprev = 0; rdchk = 0; dprev = '0; rdexp = '0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        tprev = 0; rdchk = 0; ref_ptr = 1;
        continue;
      end
      if (rdchk) begin
        check("rdata_after_done", 32'(rdata), 32'(rdexp));
        rdchk = 0;
      end
      if (busy) check("gnt_while_busy", 32'(gnt), 32'(0));
      else begin
        eg = (req == 2'b11) ? ((ref_ptr == 1) ? 2'b01 : 2'b10) : req;
        check("gnt", 32'(gnt), 32'(eg));
        if (eg != '0) ref_ptr = eg[1] ? 1 : 0;
      end
      if (trmt && !tprev) begin
        frames_seen++;
        if (exp_frames.size() == 0) check("frame_expected", 32'(0), 32'(1));
        else check("tx_frame", 32'(tx_data), 32'(exp_frames.pop_front()));
      end
      if (trmt && tprev) check("tx_data_stable", 32'(tx_data), 32'(dprev));
      tprev = trmt; dprev = tx_data;
      if (clr_tx_done) last_clr_tx_cyc = cyc;
      if (done != '0) begin
        if (exp_done.size() == 0) check("done_expected", 32'(0), 32'(1));
        else begin
          it = exp_done.pop_front();
          check("done_owner", 32'(done), 32'(it.d));
          check("err", 32'(err), 32'(it.e));
          if (it.tmo) check("timeout_latency", 32'(cyc - last_clr_tx_cyc), 32'(TMO + 1));
          rdchk = 1; rdexp = it.r;
        end
      end else check("err_without_done", 32'(err), 32'(0));
    end
  end

  task automatic set_req(input int i, input bit w, input logic [3:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Reference transaction: frames to expect and the completion it should produce.
  task automatic expect_txn(input int i, input bit noresp);
    bit w;
    logic [3:0] a;
    logic [7:0] d;
    done_t it;
    w = we[i]; a = addr[i*AW +: AW]; d = wdata[i*DW +: DW];
    exp_frames.push_back(FW'(w));
    exp_frames.push_back(FW'(a));
    it.d = 2'(1 << i); it.e = 1'b0; it.tmo = 1'b0;
    if (w) begin
      exp_frames.push_back(d);
      ref_mem[a] = d;
      it.r = ref_last;
    end else if (noresp) begin
      it.e = 1'b1; it.tmo = 1'b1; it.r = ref_last;
    end else begin
      ref_last = ref_mem[a];
      it.r = ref_last;
    end
    exp_done.push_back(it);
  endtask

  task automatic wait_gnt(output int who);
    who = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gnt != '0) begin who = gnt[1] ? 1 : 0; break; end
    end
    if (who < 0) check("gnt_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done != '0) begin seen = 1; break; end
    end
    if (!seen) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_txn(input int i, input bit w, input logic [3:0] a, input logic [7:0] d,
                        input bit noresp, output int who);
    @(posedge clk); #1;
    set_req(i, w, a, d);
    mute = noresp;
    wait_gnt(who);
    if (who >= 0) expect_txn(who, noresp);
    @(posedge clk); #1;
    req[i] = 1'b0;
    if (who >= 0) wait_done();
    mute = 0;
  endtask

  // Both requesters held high; each granted requester immediately re-requests.
  task automatic run_both(input int n, input bit chk_order);
    int who;
    @(posedge clk); #1;
    set_req(0, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
    set_req(1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
    for (int k = 0; k < n; k++) begin
      wait_gnt(who);
      if (who < 0) break;
      if (chk_order) check("grant_order", 32'(who), 32'(k % 2));
      expect_txn(who, 0);
      @(posedge clk); #1;
      if (k == n - 1) req = '0;
      else set_req(who, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
      wait_done();
    end
    req = '0;
  endtask

  initial begin : driver
    int who, base;
    foreach (ref_mem[k]) ref_mem[k] = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_trmt", 32'(trmt), 32'(0));
    check("rst_clr_tx", 32'(clr_tx_done), 32'(0));
    check("rst_clr_rx", 32'(clr_rx_done), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_tx_data", 32'(tx_data), 32'(0));
    @(posedge clk); #3;
    rst_l = 1'b1;

    do_txn(0, 1'b1, 4'd3, 8'hA5, 1'b0, who);
    check("write_who", 32'(who), 32'(0));
    do_txn(1, 1'b0, 4'd3, 8'h00, 1'b0, who);
    check("read_who", 32'(who), 32'(1));
    run_both(4, 1'b1);

    do_txn(0, 1'b0, 4'd3, 8'h00, 1'b1, who);

    @(posedge clk); #1;
    stray_cnt++;
    repeat (6) @(negedge clk);
    check("stray_cleared", 32'(stray_cleared), 32'(1));
    check("stray_rx_done", 32'(rx_done), 32'(0));
    check("stray_rdata", 32'(rdata), 32'(ref_last));

    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd5, 8'h00);
    base = frames_seen;
    wait_gnt(who);
    if (who >= 0) expect_txn(who, 0);
    @(posedge clk); #1;
    req = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frames_seen >= base + 2) break;
    end
    check("reached_send_addr", 32'(frames_seen >= base + 2), 32'(1));
    #2 rst_l = 1'b0;
    #1;
    check("midrst_trmt", 32'(trmt), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_rdata", 32'(rdata), 32'(0));
    exp_frames.delete();
    exp_done.delete();
    ref_last = '0;
    repeat (3) @(posedge clk);
    #3 rst_l = 1'b1;
    do_txn(1, 1'b0, 4'd3, 8'h00, 1'b0, who);
    check("post_reset_who", 32'(who), 32'(1));

    for (int t = 0; t < 20; t++)
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
             8'($urandom), 1'b0, who);
    run_both(6, 1'b0);

    repeat (4) @(negedge clk);
    check("frames_drained", 32'(exp_frames.size()), 32'(0));
    check("dones_drained", 32'(exp_done.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
